// File: rtl/mem_access_pkg.sv
// Shared types and constants for the memory-access unit that replaces the
// fixed MAR/MDR pair and the direct RAM hookup.
package mem_access_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ACCESS   = 2'd1,
        COMPLETE = 2'd2
    } mau_state_t;

    localparam logic MAU_RD = 1'b0;
    localparam logic MAU_WR = 1'b1;

endpackage

// File: rtl/mem_timeout_ctr.sv
// Counts ACCESS cycles without an acknowledge and flags the last allowed one.
// A TIMEOUT of 0 removes the counter so the unit can wait forever.
module mem_timeout_ctr #(
    parameter int TIMEOUT = 15
) (
    input  logic clk,
    input  logic clr,
    input  logic clr_cnt,
    input  logic en,
    output logic expired
);

    localparam int CNT_W = (TIMEOUT > 0) ? (($clog2(TIMEOUT + 1) > 0) ? $clog2(TIMEOUT + 1) : 1) : 1;

    generate
        if (TIMEOUT == 0) begin : g_off
            assign expired = 1'b0;
        end else begin : g_on
            localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

            logic [CNT_W-1:0] cnt;

            always_ff @(posedge clk or negedge clr) begin
                if (!clr) begin
                    cnt <= '0;
                end else if (clr_cnt) begin
                    cnt <= '0;
                end else if (en) begin
                    cnt <= cnt + 1'b1;
                end
            end

            // The current cycle is the last one allowed without an ack.
            assign expired = (cnt == LAST);
        end
    endgenerate

endmodule

// File: rtl/mem_access_unit.sv
// MAR/MDR pair plus a req/ack memory handshake with a timeout. The control
// unit pulses rd_start or wr_start and waits for done.
module mem_access_unit
    import mem_access_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 9,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              clr,
    input  logic [DATA_W-1:0] bus_in,
    input  logic              mar_in,
    input  logic              mdr_in,
    input  logic              rd_start,
    input  logic              wr_start,
    output logic [ADDR_W-1:0] mar_q,
    output logic [DATA_W-1:0] mdr_q,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack
);

    mau_state_t        state;
    mau_state_t        state_nxt;
    logic [ADDR_W-1:0] mar_nxt;
    logic [DATA_W-1:0] mdr_nxt;
    logic              we_nxt;
    logic [ADDR_W-1:0] addr_nxt;
    logic [DATA_W-1:0] wdata_nxt;
    logic              err_nxt;
    logic              cnt_clr;
    logic              cnt_en;
    logic              expired;

    mem_timeout_ctr #(
        .TIMEOUT(TIMEOUT)
    ) u_timeout (
        .clk    (clk),
        .clr    (clr),
        .clr_cnt(cnt_clr),
        .en     (cnt_en),
        .expired(expired)
    );

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        mar_nxt   = mar_q;
        mdr_nxt   = mdr_q;
        we_nxt    = mem_we;
        addr_nxt  = mem_addr;
        wdata_nxt = mem_wdata;
        err_nxt   = err;
        cnt_clr   = 1'b0;
        cnt_en    = 1'b0;
        case (state)
            IDLE: begin
                if (mar_in) begin
                    mar_nxt = bus_in[ADDR_W-1:0];
                end
                if (mdr_in) begin
                    mdr_nxt = bus_in;
                end
                // The memory side sees the freshly loaded MAR/MDR, so a
                // load and a start in the same cycle act as one step.
                if (rd_start ^ wr_start) begin
                    we_nxt    = wr_start ? MAU_WR : MAU_RD;
                    addr_nxt  = mar_nxt;
                    wdata_nxt = mdr_nxt;
                    err_nxt   = 1'b0;
                    cnt_clr   = 1'b1;
                    state_nxt = ACCESS;
                end else if (rd_start && wr_start) begin
                    err_nxt = 1'b1;
                end
            end
            ACCESS: begin
                if (mem_ack) begin
                    if (mem_we == MAU_RD) begin
                        mdr_nxt = mem_rdata;
                    end
                    state_nxt = COMPLETE;
                end else begin
                    cnt_en = 1'b1;
                    if (expired) begin
                        err_nxt   = 1'b1;
                        state_nxt = COMPLETE;
                    end
                end
            end
            COMPLETE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            mar_q     <= '0;
            mdr_q     <= '0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            err       <= 1'b0;
        end else begin
            mar_q     <= mar_nxt;
            mdr_q     <= mdr_nxt;
            mem_we    <= we_nxt;
            mem_addr  <= addr_nxt;
            mem_wdata <= wdata_nxt;
            err       <= err_nxt;
        end
    end

    assign busy    = (state != IDLE);
    assign done    = (state == COMPLETE);
    assign mem_req = (state == ACCESS);

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: a per-cycle vector table plus
// hand-written timeout, last-cycle ack and mid-access reset sequences.
module tb_mem_access_unit;

    logic        clk;
    logic        clr;
    logic [31:0] bus_in;
    logic        mar_in;
    logic        mdr_in;
    logic        rd_start;
    logic        wr_start;
    logic [8:0]  mar_q;
    logic [31:0] mdr_q;
    logic        busy;
    logic        done;
    logic        err;
    logic        mem_req;
    logic        mem_we;
    logic [8:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        mar_in;
        logic        mdr_in;
        logic        rd;
        logic        wr;
        logic [31:0] bus;
        logic        ack;
        logic [31:0] rdata;
        logic        busy;
        logic        done;
        logic        err;
        logic        req;
        logic        we;
        logic [8:0]  mar;
        logic [31:0] mdr;
        logic [8:0]  addr;
        logic [31:0] wdata;
    } vec_t;

    localparam int NV = 17;
    vec_t tbl [NV];

    mem_access_unit #(
        .DATA_W (32),
        .ADDR_W (9),
        .TIMEOUT(15)
    ) dut (
        .clk      (clk),
        .clr      (clr),
        .bus_in   (bus_in),
        .mar_in   (mar_in),
        .mdr_in   (mdr_in),
        .rd_start (rd_start),
        .wr_start (wr_start),
        .mar_q    (mar_q),
        .mdr_q    (mdr_q),
        .busy     (busy),
        .done     (done),
        .err      (err),
        .mem_req  (mem_req),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .mem_ack  (mem_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] simulation did not finish");
    end

    function automatic vec_t mk(
        input logic mi, input logic di, input logic r, input logic w,
        input logic [31:0] b, input logic a, input logic [31:0] rd,
        input logic e_busy, input logic e_done, input logic e_err,
        input logic e_req, input logic e_we, input logic [8:0] e_mar,
        input logic [31:0] e_mdr, input logic [8:0] e_addr,
        input logic [31:0] e_wdata);
        vec_t v;
        v.mar_in = mi;     v.mdr_in = di;   v.rd = r;       v.wr = w;
        v.bus    = b;      v.ack    = a;    v.rdata = rd;
        v.busy   = e_busy; v.done   = e_done; v.err = e_err;
        v.req    = e_req;  v.we     = e_we;   v.mar = e_mar;
        v.mdr    = e_mdr;  v.addr   = e_addr; v.wdata = e_wdata;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=0x%0h required=0x%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        mar_in    = v.mar_in;
        mdr_in    = v.mdr_in;
        rd_start  = v.rd;
        wr_start  = v.wr;
        bus_in    = v.bus;
        mem_ack   = v.ack;
        mem_rdata = v.rdata;
    endtask

    task automatic idleInputs();
        mar_in = 1'b0; mdr_in = 1'b0; rd_start = 1'b0; wr_start = 1'b0;
        bus_in = '0;   mem_ack = 1'b0; mem_rdata = '0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int cycles;
        int done_seen;

        // read zero-wait, write with loads and 3 waits, illegal, stray ack, ignored inputs
        tbl[0]  = mk(1,0,0,0, 32'h5,        0, 32'h0,        0,0,0,0,0, 9'h5,  32'h0,        9'h0,  32'h0);
        tbl[1]  = mk(0,0,1,0, 32'h0,        0, 32'h0,        1,0,0,1,0, 9'h5,  32'h0,        9'h5,  32'h0);
        tbl[2]  = mk(0,0,0,0, 32'h0,        1, 32'hDEADBEEF, 1,1,0,0,0, 9'h5,  32'hDEADBEEF, 9'h5,  32'h0);
        tbl[3]  = mk(0,0,0,0, 32'h0,        0, 32'h0,        0,0,0,0,0, 9'h5,  32'hDEADBEEF, 9'h5,  32'h0);
        tbl[4]  = mk(1,1,0,1, 32'h12,       0, 32'h0,        1,0,0,1,1, 9'h12, 32'h12,       9'h12, 32'h12);
        tbl[5]  = mk(0,0,0,0, 32'h0,        0, 32'h0,        1,0,0,1,1, 9'h12, 32'h12,       9'h12, 32'h12);
        tbl[6]  = mk(0,0,0,0, 32'h0,        0, 32'h0,        1,0,0,1,1, 9'h12, 32'h12,       9'h12, 32'h12);
        tbl[7]  = mk(0,0,0,0, 32'h0,        0, 32'h0,        1,0,0,1,1, 9'h12, 32'h12,       9'h12, 32'h12);
        tbl[8]  = mk(0,0,0,0, 32'h0,        1, 32'hFFFFFFFF, 1,1,0,0,1, 9'h12, 32'h12,       9'h12, 32'h12);
        tbl[9]  = mk(0,0,0,0, 32'h0,        0, 32'h0,        0,0,0,0,1, 9'h12, 32'h12,       9'h12, 32'h12);
        tbl[10] = mk(0,0,1,1, 32'h0,        0, 32'h0,        0,0,1,0,1, 9'h12, 32'h12,       9'h12, 32'h12);
        tbl[11] = mk(0,0,0,0, 32'h0,        1, 32'hAAAAAAAA, 0,0,1,0,1, 9'h12, 32'h12,       9'h12, 32'h12);
        tbl[12] = mk(0,0,1,0, 32'h0,        0, 32'h0,        1,0,0,1,0, 9'h12, 32'h12,       9'h12, 32'h12);
        tbl[13] = mk(1,1,1,0, 32'h7,        0, 32'h0,        1,0,0,1,0, 9'h12, 32'h12,       9'h12, 32'h12);
        tbl[14] = mk(0,0,0,0, 32'h0,        1, 32'h0BADF00D, 1,1,0,0,0, 9'h12, 32'h0BADF00D, 9'h12, 32'h12);
        tbl[15] = mk(0,0,1,0, 32'h0,        0, 32'h0,        0,0,0,0,0, 9'h12, 32'h0BADF00D, 9'h12, 32'h12);
        tbl[16] = mk(0,0,0,0, 32'h0,        0, 32'h0,        0,0,0,0,0, 9'h12, 32'h0BADF00D, 9'h12, 32'h12);

        clr = 1'b0;
        idleInputs();
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_busy",  {31'b0, busy},    32'h0);
        checkOutput("rst_done",  {31'b0, done},    32'h0);
        checkOutput("rst_err",   {31'b0, err},     32'h0);
        checkOutput("rst_req",   {31'b0, mem_req}, 32'h0);
        checkOutput("rst_we",    {31'b0, mem_we},  32'h0);
        checkOutput("rst_mar",   {23'b0, mar_q},   32'h0);
        checkOutput("rst_mdr",   mdr_q,            32'h0);
        checkOutput("rst_addr",  {23'b0, mem_addr}, 32'h0);
        checkOutput("rst_wdata", mem_wdata,        32'h0);
        clr = 1'b1;

        for (int i = 0; i < NV; i++) begin
            applyStimulus(tbl[i]);
            step();
            checkOutput($sformatf("row%0d_busy", i),  {31'b0, busy},     {31'b0, tbl[i].busy});
            checkOutput($sformatf("row%0d_done", i),  {31'b0, done},     {31'b0, tbl[i].done});
            checkOutput($sformatf("row%0d_err", i),   {31'b0, err},      {31'b0, tbl[i].err});
            checkOutput($sformatf("row%0d_req", i),   {31'b0, mem_req},  {31'b0, tbl[i].req});
            checkOutput($sformatf("row%0d_we", i),    {31'b0, mem_we},   {31'b0, tbl[i].we});
            checkOutput($sformatf("row%0d_mar", i),   {23'b0, mar_q},    {23'b0, tbl[i].mar});
            checkOutput($sformatf("row%0d_mdr", i),   mdr_q,             tbl[i].mdr);
            checkOutput($sformatf("row%0d_addr", i),  {23'b0, mem_addr}, {23'b0, tbl[i].addr});
            checkOutput($sformatf("row%0d_wdata", i), mem_wdata,         tbl[i].wdata);
        end
        idleInputs();

        // timeout: request held for exactly 15 cycles, MDR untouched
        rd_start = 1'b1;
        step();
        rd_start = 1'b0;
        cycles = 0;
        while (mem_req && cycles < 100) begin
            cycles++;
            step();
        end
        checkOutput("to_req_cycles", cycles,              32'd15);
        checkOutput("to_done",       {31'b0, done},       32'h1);
        checkOutput("to_err",        {31'b0, err},        32'h1);
        checkOutput("to_mdr",        mdr_q,               32'h0BADF00D);
        step();
        checkOutput("to_idle_busy",  {31'b0, busy},       32'h0);
        checkOutput("to_err_sticky", {31'b0, err},        32'h1);
        rd_start = 1'b1;
        step();
        rd_start = 1'b0;
        checkOutput("to_err_clear",  {31'b0, err},        32'h0);
        mem_ack = 1'b1;
        mem_rdata = 32'h55;
        step();
        idleInputs();
        checkOutput("to_next_done",  {31'b0, done},       32'h1);
        checkOutput("to_next_mdr",   mdr_q,               32'h55);
        step();

        // ack in the 15th ACCESS cycle wins over the timeout
        rd_start = 1'b1;
        step();
        rd_start = 1'b0;
        repeat (14) step();
        checkOutput("last_req",      {31'b0, mem_req},    32'h1);
        mem_ack = 1'b1;
        mem_rdata = 32'h66;
        step();
        idleInputs();
        checkOutput("last_done",     {31'b0, done},       32'h1);
        checkOutput("last_err",      {31'b0, err},        32'h0);
        checkOutput("last_mdr",      mdr_q,               32'h66);
        step();

        // reset asserted in the 2nd ACCESS cycle
        mar_in = 1'b1;
        bus_in = 32'h33;
        step();
        idleInputs();
        rd_start = 1'b1;
        step();
        rd_start = 1'b0;
        step();
        checkOutput("mid_req_before", {31'b0, mem_req},   32'h1);
        #2;
        clr = 1'b0;
        #1;
        checkOutput("mid_req",  {31'b0, mem_req},         32'h0);
        checkOutput("mid_busy", {31'b0, busy},            32'h0);
        checkOutput("mid_mar",  {23'b0, mar_q},           32'h0);
        checkOutput("mid_mdr",  mdr_q,                    32'h0);
        step();
        clr = 1'b1;
        done_seen = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            if (done) done_seen++;
        end
        checkOutput("mid_no_done", done_seen,             32'd0);
        mar_in = 1'b1;
        bus_in = 32'h9;
        step();
        idleInputs();
        rd_start = 1'b1;
        step();
        rd_start = 1'b0;
        checkOutput("mid_new_addr", {23'b0, mem_addr},    32'h9);
        mem_ack = 1'b1;
        mem_rdata = 32'h1234;
        step();
        idleInputs();
        checkOutput("mid_new_done", {31'b0, done},        32'h1);
        checkOutput("mid_new_mdr",  mdr_q,                32'h1234);
        checkOutput("mid_new_err",  {31'b0, err},         32'h0);
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Parametrised memory-access unit that replaces the fixed MAR/MDR pair and the direct RAM hookup in the CPU datapath. It holds the address register (MAR) and data register (MDR), and it runs each read or write as a req/ack handshake with a memory of variable latency. A timeout flags memory that never answers. The control unit issues single-cycle start pulses and waits for `done`. The MDR value drives the bus mux input as before.

## Interface
- `DATA_W`, default 32: data and bus width.
- `ADDR_W`, default 9: memory address width; MAR holds `bus_in[ADDR_W-1:0]`.
- `TIMEOUT`, default 15: maximum number of ACCESS cycles without `mem_ack`; the value 0 disables the timeout.

Ports:
- `clk`  in  1: the single clock; every flop is rising-edge.
- `clr`  in  1: reset, asynchronous and active-low.
- `bus_in`  in  DATA_W: the datapath bus (`BusMuxOut`).
- `mar_in`  in  1: load MAR from the bus.
- `mdr_in`  in  1: load MDR from the bus.
- `rd_start`  in  1: start a read of the word at MAR into MDR.
- `wr_start`  in  1: start a write of MDR to the word at MAR.
- `mar_q`  out  ADDR_W: current MAR value.
- `mdr_q`  out  DATA_W: current MDR value, which is the bus mux input.
- `busy`  out  1: an access is in progress (state is not IDLE).
- `done`  out  1: one-cycle completion pulse.
- `err`  out  1: sticky error flag (timeout or illegal start).
- `mem_req`  out  1: memory request.
- `mem_we`  out  1: 1 for a write, 0 for a read; valid while `mem_req` is high.
- `mem_addr`  out  ADDR_W: access address, held stable while `mem_req` is high.
- `mem_wdata`  out  DATA_W: write data, held stable while `mem_req` is high.
- `mem_rdata`  in  DATA_W: read data; it must be valid in the same cycle as `mem_ack`.
- `mem_ack`  in  1: memory completion; it is sampled only in the ACCESS state.

## Operation
- The FSM has three states: IDLE, ACCESS and COMPLETE.
- **Accepted start:** a start is accepted in IDLE when exactly one of `rd_start`/`wr_start` is high.
  - The unit latches `mem_we`.
  - It latches `mem_addr` as `mar_in ? bus_in[ADDR_W-1:0] : mar_q`. MAR itself also loads when `mar_in` is high, so a same-cycle load-and-start uses the new address.
  - It latches `mem_wdata` as `mdr_in ? bus_in : mdr_q` in the same way, with MDR also loading when `mdr_in` is high.
  - It clears `err` and the timeout counter, then moves to ACCESS.
- **Illegal start:** both start inputs high in IDLE leaves the state in IDLE, sets `err`, and changes nothing else.
- **ACCESS state:** `mem_req` is 1.
  - On `mem_ack`: a read loads MDR with `mem_rdata`, and the FSM moves to COMPLETE.
  - Without `mem_ack`: the counter increments. When the counter equals `TIMEOUT-1` (with `TIMEOUT` > 0), the FSM moves to COMPLETE, sets `err`, and leaves MDR unchanged.
- **COMPLETE state:** `done` is 1 and `mem_req` is 0. The FSM returns to IDLE unconditionally.
- **Inputs outside IDLE:** `mar_in`, `mdr_in` and both start inputs are ignored while `busy` is high. MAR and MDR are frozen for the whole access.
- **Loads in IDLE:** `mar_in` and `mdr_in` take effect on every IDLE clock edge, whether or not a start is present.
- **Stray acknowledge:** a `mem_ack` outside ACCESS has no effect.
- **Stalled memory:** with `TIMEOUT` = 0 the unit waits in ACCESS indefinitely.

## Timing
- **Reset values:** IDLE state, MAR = 0, MDR = 0, `busy`/`done`/`err`/`mem_req`/`mem_we` = 0, `mem_addr` = 0, `mem_wdata` = 0, counter = 0.
- **Reset mid-operation:** assertion of `clr` takes effect immediately. `mem_req` drops asynchronously and no `done` is produced.
- **Outputs:** all outputs are registered or decoded from state; there are no combinational paths from any input to any output.
- **Cycle numbering:** the start is sampled at the edge that ends cycle 0.
  - `mem_req` is high from cycle 1.
  - If `mem_ack` arrives in cycle k, then `done` is high and the new `mdr_q` is visible in cycle k+1.
  - Minimum latency from start to `done` is 2 cycles; a new start is accepted no earlier than cycle k+2.
- **Timeout:** `mem_req` stays high for exactly `TIMEOUT` cycles; `done` and `err` both appear in cycle `TIMEOUT`+1.
- **Acknowledge on the last allowed cycle:** the ack wins. The access completes normally and `err` stays 0.

## Structure
- **Package `mem_access_pkg`:**
  - the state enum typedef `mau_state_t` (IDLE, ACCESS, COMPLETE);
  - constants `MAU_RD` = 1'b0 and `MAU_WR` = 1'b1.
- **Sub-module `mem_timeout_ctr`:**
  - parameter `TIMEOUT`; counter width `$clog2(TIMEOUT+1)`, minimum 1;
  - inputs `clr_cnt` and `en`; output `expired`;
  - tied off (`expired` = 0) when `TIMEOUT` = 0.
- **Top level:** the top holds MAR, MDR, the latched memory-side registers and the FSM.

## Test plan
- **Read, zero wait:** `mar_in` with `bus_in` = 0x0000_0005, then `rd_start`; memory acks in the first ACCESS cycle with `mem_rdata` = 0xDEAD_BEEF → `mem_addr` = 5, `mem_we` = 0, `done` 2 cycles after the start, `mdr_q` = 0xDEAD_BEEF, `err` = 0.
- **Write with same-cycle loads and 3 wait states:** `mar_in` + `mdr_in` + `wr_start` in the same cycle with `bus_in` = 0x0000_0012; memory acks in the 4th ACCESS cycle → `mem_addr` = 0x12, `mem_wdata` = 0x12, `mem_we` = 1, `mem_req` high for 4 cycles, `done` in the following cycle.
- **Timeout, `TIMEOUT` = 15:** `rd_start` with no ack → `mem_req` high for exactly 15 cycles, then `done` = 1 and `err` = 1; `mdr_q` keeps its prior value; the next accepted `rd_start` clears `err`.
- **Illegal and ignored inputs:** `rd_start` and `wr_start` together in IDLE → no `mem_req`, `err` = 1. Then, during an access, `mar_in` with `bus_in` = 0x7 and a second `rd_start` → MAR and `mem_addr` unchanged, and only one `done` is produced.
- **Reset mid-access:** `clr` driven low in the 2nd ACCESS cycle → `mem_req`, `busy`, `mar_q` and `mdr_q` are 0 immediately; no `done` after `clr` rises; a new read then completes normally.
